// File: rtl/mem_slave_if.sv
// Valid/ready memory request bus shared by the BFM, the monitor and mem_slave.
// The counters travel with the bus so observers see them through one handle.
interface mem_slave_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [WIDTH-1:0]      wdata;
  logic                  wr_rd;
  logic                  valid;
  logic [WIDTH-1:0]      rdata;
  logic                  ready;
  logic                  err;
  logic [15:0]           wr_cnt;
  logic [15:0]           rd_cnt;

  modport master (
    output addr, wdata, wr_rd, valid,
    input  rdata, ready, err, wr_cnt, rd_cnt
  );

  modport slave (
    input  addr, wdata, wr_rd, valid,
    output rdata, ready, err, wr_cnt, rd_cnt
  );
endinterface

// File: rtl/mem_slave.sv
// Memory responder: captures one request, waits WAIT_CYCLES, pulses ready.
// All outputs and the storage array are registered.
module mem_slave #(
  parameter int WIDTH       = 16,
  parameter int ADDR_WIDTH  = 4,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input logic       clk,
  input logic       rst,
  mem_slave_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      wdata;
    logic                  wr_rd;
  } req_t;

  localparam int CW =
    (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CLAST =
    CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [ADDR_WIDTH:0] ALIM =
    (ADDR_WIDTH + 1)'(DEPTH);

  state_t state;
  state_t state_nxt;
  logic [CW-1:0] cnt;

  req_t req_in;
  req_t req_q;
  req_t req_cur;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [WIDTH-1:0]      rdata_q;
  logic                  ready_q;
  logic                  err_q;
  logic [15:0]           wr_cnt_q;
  logic [15:0]           rd_cnt_q;

  logic [WIDTH-1:0]      rdata_nxt;
  logic                  ready_nxt;
  logic                  err_nxt;
  logic [15:0]           wr_cnt_nxt;
  logic [15:0]           rd_cnt_nxt;
  logic                  we;
  logic                  fire;
  logic                  oor;
  logic [ADDR_WIDTH-1:0] idx;

  assign bus.rdata  = rdata_q;
  assign bus.ready  = ready_q;
  assign bus.err    = err_q;
  assign bus.wr_cnt = wr_cnt_q;
  assign bus.rd_cnt = rd_cnt_q;

  always_comb begin
    req_in       = '0;
    req_in.addr  = bus.addr;
    req_in.wdata = bus.wdata;
    req_in.wr_rd = bus.wr_rd;
  end

  // With zero wait states the response is built from the live inputs.
  assign req_cur = (state == S_IDLE) ? req_in : req_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:
        if (bus.valid) begin
          state_nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
      S_WAIT:
        if (cnt == CLAST) begin
          state_nxt = S_RESP;
        end
      S_RESP:
        state_nxt = S_DONE;
      S_DONE:
        if (!bus.valid) begin
          state_nxt = S_IDLE;
        end
      default:
        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      req_q <= '0;
    end else begin
      if (state == S_IDLE && bus.valid) begin
        req_q <= req_in;
        cnt   <= '0;
      end else if (state == S_WAIT) begin
        cnt <= (cnt == CLAST) ? '0 : cnt + CW'(1);
      end
    end
  end

  assign fire = (state != S_RESP) && (state_nxt == S_RESP);
  assign oor  = {1'b0, req_cur.addr} >= ALIM;
  assign idx  = oor ? '0 : req_cur.addr;

  always_comb begin
    rdata_nxt  = rdata_q;
    ready_nxt  = 1'b0;
    err_nxt    = 1'b0;
    wr_cnt_nxt = wr_cnt_q;
    rd_cnt_nxt = rd_cnt_q;
    we         = 1'b0;
    unique case (1'b1)
      fire && req_cur.wr_rd: begin
        ready_nxt  = 1'b1;
        err_nxt    = oor;
        rdata_nxt  = '0;
        wr_cnt_nxt = wr_cnt_q + 16'd1;
        we         = !oor;
      end
      fire && !req_cur.wr_rd: begin
        ready_nxt  = 1'b1;
        err_nxt    = oor;
        rdata_nxt  = oor ? '0 : mem[idx];
        rd_cnt_nxt = rd_cnt_q + 16'd1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      rdata_q  <= rdata_nxt;
      ready_q  <= ready_nxt;
      err_q    <= err_nxt;
      wr_cnt_q <= wr_cnt_nxt;
      rd_cnt_q <= rd_cnt_nxt;
      if (we) begin
        mem[idx] <= req_cur.wdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_slave.sv
// Directed bench for mem_slave: two instances cover the waited/ranged
// configuration and the zero-wait full-depth configuration.
module tb_mem_slave;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   ew[2];
  int   er[2];

  mem_slave_if #(.WIDTH(16), .ADDR_WIDTH(4)) b0 ();
  mem_slave_if #(.WIDTH(16), .ADDR_WIDTH(4)) b1 ();

  mem_slave #(
    .WIDTH(16), .ADDR_WIDTH(4), .DEPTH(12), .WAIT_CYCLES(2)
  ) u0 (
    .clk(clk), .rst(rst), .bus(b0)
  );

  mem_slave #(
    .WIDTH(16), .ADDR_WIDTH(4), .DEPTH(16), .WAIT_CYCLES(0)
  ) u1 (
    .clk(clk), .rst(rst), .bus(b1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int s, input logic v, input logic w,
                       input logic [3:0] a, input logic [15:0] d);
    if (s == 0) begin
      b0.valid = v; b0.wr_rd = w; b0.addr = a; b0.wdata = d;
    end else begin
      b1.valid = v; b1.wr_rd = w; b1.addr = a; b1.wdata = d;
    end
  endtask

  function automatic logic rdy(input int s);
    return (s == 0) ? b0.ready : b1.ready;
  endfunction

  function automatic logic erf(input int s);
    return (s == 0) ? b0.err : b1.err;
  endfunction

  function automatic logic [15:0] rdat(input int s);
    return (s == 0) ? b0.rdata : b1.rdata;
  endfunction

  function automatic logic [15:0] wcnt(input int s);
    return (s == 0) ? b0.wr_cnt : b1.wr_cnt;
  endfunction

  function automatic logic [15:0] rcnt(input int s);
    return (s == 0) ? b0.rd_cnt : b1.rd_cnt;
  endfunction

  // One request; valid stays up for 'hold' cycles past ready with
  // scrambled fields, which must neither re-execute nor be re-captured.
  task automatic txn(input int s, input logic w,
                     input logic [3:0] a, input logic [15:0] d,
                     input int lat_exp, input logic e_exp,
                     input logic [15:0] r_exp, input int hold);
    int    lat;
    string t;
    lat = 0;
    t = $sformatf("u%0d %s a=%0d", s, w ? "wr" : "rd", a);
    @(negedge clk);
    drive(s, 1'b1, w, a, d);
    do begin
      @(negedge clk);
      lat++;
    end while (!rdy(s) && lat < 20);
    if (w) ew[s]++;
    else er[s]++;
    chk({t, " latency"}, lat, lat_exp);
    chk({t, " err"}, erf(s), e_exp);
    chk({t, " rdata"}, rdat(s), r_exp);
    chk({t, " wr_cnt"}, wcnt(s), ew[s]);
    chk({t, " rd_cnt"}, rcnt(s), er[s]);
    drive(s, 1'b1, ~w, a ^ 4'hF, ~d);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({t, " ready pulse"}, rdy(s), 1'b0);
      chk({t, " err clear"}, erf(s), 1'b0);
      chk({t, " rdata hold"}, rdat(s), r_exp);
      chk({t, " wr_cnt hold"}, wcnt(s), ew[s]);
      chk({t, " rd_cnt hold"}, rcnt(s), er[s]);
    end
    drive(s, 1'b0, 1'b0, 4'h0, 16'h0);
  endtask

  initial begin
    ew = '{0, 0};
    er = '{0, 0};
    drive(0, 1'b0, 1'b0, 4'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 4'h0, 16'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("u%0d reset ready", s), rdy(s), 1'b0);
      chk($sformatf("u%0d reset err", s), erf(s), 1'b0);
      chk($sformatf("u%0d reset rdata", s), rdat(s), 16'h0);
      chk($sformatf("u%0d reset wr_cnt", s), wcnt(s), 16'h0);
      chk($sformatf("u%0d reset rd_cnt", s), rcnt(s), 16'h0);
    end
    rst = 1'b0;

    txn(0, 1'b1, 4'd3,  16'hA5A5, 3, 1'b0, 16'h0000, 1);
    txn(0, 1'b0, 4'd3,  16'h0000, 3, 1'b0, 16'hA5A5, 1);
    txn(0, 1'b1, 4'd2,  16'h5A5A, 3, 1'b0, 16'h0000, 3);
    txn(0, 1'b1, 4'd14, 16'hBEEF, 3, 1'b1, 16'h0000, 1);
    txn(0, 1'b0, 4'd14, 16'h0000, 3, 1'b1, 16'h0000, 1);
    txn(0, 1'b0, 4'd2,  16'h0000, 3, 1'b0, 16'h5A5A, 1);
    txn(0, 1'b1, 4'd11, 16'h1111, 3, 1'b0, 16'h0000, 1);
    txn(0, 1'b0, 4'd11, 16'h0000, 3, 1'b0, 16'h1111, 1);
    txn(0, 1'b0, 4'd12, 16'h0000, 3, 1'b1, 16'h0000, 1);
    txn(0, 1'b0, 4'd3,  16'h0000, 3, 1'b0, 16'hA5A5, 1);

    // Reset lands while the write to addr 5 is in its wait states.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 4'd5, 16'h7777);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    ew[0] = 0;
    er[0] = 0;
    chk("async rst ready", rdy(0), 1'b0);
    chk("async rst err", erf(0), 1'b0);
    chk("async rst rdata", rdat(0), 16'h0);
    chk("async rst wr_cnt", wcnt(0), 16'h0);
    chk("async rst rd_cnt", rcnt(0), 16'h0);
    drive(0, 1'b0, 1'b0, 4'h0, 16'h0);
    @(negedge clk);
    rst = 1'b0;

    txn(0, 1'b0, 4'd5, 16'h0000, 3, 1'b0, 16'h0000, 1);
    txn(0, 1'b0, 4'd3, 16'h0000, 3, 1'b0, 16'h0000, 1);
    txn(0, 1'b1, 4'd5, 16'h7777, 3, 1'b0, 16'h0000, 1);
    txn(0, 1'b0, 4'd5, 16'h0000, 3, 1'b0, 16'h7777, 1);

    txn(1, 1'b1, 4'd0,  16'h1234, 1, 1'b0, 16'h0000, 1);
    txn(1, 1'b0, 4'd0,  16'h0000, 1, 1'b0, 16'h1234, 1);
    txn(1, 1'b1, 4'd15, 16'hCAFE, 1, 1'b0, 16'h0000, 2);
    txn(1, 1'b0, 4'd15, 16'h0000, 1, 1'b0, 16'hCAFE, 1);
    txn(1, 1'b0, 4'd0,  16'h0000, 1, 1'b0, 16'h1234, 1);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_slave.md
Name: mem_slave

Overview:
- Responder end of the memory valid/ready interface.
- Accepts write and read requests from the driving BFM, stores data in an internal register array, and returns `rdata` with a one-cycle `ready` pulse after a programmable number of wait states.
- Used as the behavioural/synthesisable memory the BFM and monitor talk to in the memory project.

Parameters:
- WIDTH, 16, data width of `wdata`/`rdata`.
- ADDR_WIDTH, 4, address width.
- DEPTH, 16, number of implemented words (must be <= 2**ADDR_WIDTH); addresses >= DEPTH are out of range.
- WAIT_CYCLES, 2, wait states inserted between request capture and `ready` (0 allowed).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- addr  input  ADDR_WIDTH  request address.
- wdata  input  WIDTH  write data, meaningful when wr_rd=1.
- wr_rd  input  1  1=write, 0=read.
- valid  input  1  request valid from initiator.
- rdata  output  WIDTH  read data, valid while ready=1, held afterwards.
- ready  output  1  one-cycle completion pulse.
- err  output  1  asserted with ready when the captured address was out of range.
- wr_cnt  output  16  completed write count, wraps at 2**16.
- rd_cnt  output  16  completed read count, wraps at 2**16.

Behaviour:
- One clock domain, `clk`. Reset is asynchronous and active-high on `rst`. During reset:
  - `ready`=0, `err`=0, `rdata`=0, `wr_cnt`=0, `rd_cnt`=0.
  - All DEPTH memory words are cleared to 0.
  - State machine goes to IDLE; wait counter goes to 0.
- Reset mid-transaction abandons the transaction: no write, no count update.
- All outputs are registered.
- States: IDLE, WAIT, RESP, DONE.
- IDLE:
  - On an edge with valid=1, capture addr/wdata/wr_rd into holding registers.
  - Go to WAIT with counter=0 if WAIT_CYCLES>0, otherwise go directly to RESP.
- WAIT:
  - Counter increments each edge.
  - When counter==WAIT_CYCLES-1, go to RESP.
  - Inputs are ignored; the captured request is used even if the initiator changes or drops valid.
- Entering RESP (a single edge):
  - ready<=1.
  - err<=(captured addr>=DEPTH).
  - Write in range: mem[addr]<=wdata; rdata<=0; wr_cnt+1.
  - Read in range: rdata<=mem[addr]; rd_cnt+1.
  - Out of range: no memory update, rdata<=0, the matching counter still increments.
- RESP: lasts exactly one cycle. Next edge: ready<=0, err<=0, go to DONE. rdata holds its value.
- DONE:
  - Stay while valid=1. The initiator keeps valid high for one cycle after it samples ready, so this state prevents re-executing the same request.
  - On an edge with valid=0, go to IDLE. A new request is accepted from IDLE on a subsequent edge.
- Latency: with request first sampled at edge E0, ready is high in the cycle following edge E0+WAIT_CYCLES, i.e. WAIT_CYCLES+1 cycles of latency.
- Minimum request-to-request spacing is WAIT_CYCLES+3 edges.
- Read of a word written in an earlier transaction returns the new value. There is no same-cycle read/write case, since only one transaction is in flight.
- Counters wrap from 16'hFFFF to 0 without flagging.
- valid=0 while in IDLE: no state change; outputs hold.

Test Plan:
- Reset, then write addr=3 wdata=16'hA5A5 with WAIT_CYCLES=2 -> ready high for exactly one cycle, 3 cycles after valid was first sampled; err=0; wr_cnt=1; rdata=0.
- Read addr=3 after the previous write -> rdata=16'hA5A5 during the ready cycle and held afterwards; rd_cnt=1.
- Initiator holds valid high for 1 cycle after ready, then drops it -> exactly one transaction executes (count increments by 1 only); the next request is accepted only after the DONE->IDLE transition.
- DEPTH=12, write addr=14 then read addr=14 -> err=1 with each ready pulse; rdata=0; memory unchanged (read addr=2 returns its prior value); wr_cnt and rd_cnt each increment.
- WAIT_CYCLES=0: back-to-back write/read of addr=0 with 16'h1234 -> ready in the cycle immediately after valid is sampled; read returns 16'h1234.
- Assert rst while in WAIT during a write to addr=5 -> ready/err/counters go to 0 immediately (asynchronously); mem[5] reads back 0 after reset release; the next transaction completes normally.
